// File: rtl/mux_scan_serializer.sv
// rtl/mux_scan_serializer.sv - 4:1 mux driver: loads a word, scans mux select, serializes sampled mux output
// Also flags a sticky error when the sampled mux output disagrees with the data bit it should select.
module mux_scan_serializer #(
   parameter int SETTLE_CYCLES = 1,
   parameter bit LSB_FIRST     = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [3:0] load_data,
   output logic       in0,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic       addr0,
   output logic       addr1,
   input  logic       mux_out,
   output logic       ser_out,
   output logic       ser_valid,
   input  logic       ser_ready,
   output logic       ser_last,
   output logic       mux_err
);

   typedef enum logic [1:0] {IDLE, SETTLE, OUT} state_e;

   localparam int            CW        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [1:0]    FIRST_IDX = LSB_FIRST ? 2'd0 : 2'd3;
   localparam logic [1:0]    LAST_IDX  = LSB_FIRST ? 2'd3 : 2'd0;
   localparam logic [CW-1:0] CNT_END   = CW'(SETTLE_CYCLES - 1);

   state_e          state_q, state_d;
   logic [3:0]      data_q, data_d;
   logic [1:0]      addr_q, addr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ser_out_q, ser_out_d;
   logic            ser_valid_q, ser_valid_d;
   logic            ser_last_q, ser_last_d;
   logic            mux_err_q, mux_err_d;
   logic            is_last;
   logic            exp_bit;

   assign is_last = (addr_q == LAST_IDX);
   assign exp_bit = data_q[addr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         data_q      <= 4'b0000;
         addr_q      <= 2'b00;
         cnt_q       <= '0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_last_q  <= 1'b0;
         mux_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         ser_out_q   <= ser_out_d;
         ser_valid_q <= ser_valid_d;
         ser_last_q  <= ser_last_d;
         mux_err_q   <= mux_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      ser_out_d   = ser_out_q;
      ser_valid_d = ser_valid_q;
      ser_last_d  = ser_last_q;
      mux_err_d   = mux_err_q;
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               data_d    = load_data;
               addr_d    = FIRST_IDX;
               mux_err_d = 1'b0;
               cnt_d     = '0;
               state_d   = SETTLE;
            end
         end
         SETTLE: begin
            cnt_d = cnt_q + CW'(1);
            // Mux output is trusted only on the last settle edge for this index
            if (cnt_q == CNT_END) begin
               ser_out_d   = mux_out;
               ser_valid_d = 1'b1;
               ser_last_d  = is_last;
               mux_err_d   = mux_err_q | (mux_out != exp_bit);
               state_d     = OUT;
            end
         end
         OUT: begin
            if (ser_ready) begin
               ser_valid_d = 1'b0;
               ser_last_d  = 1'b0;
               if (is_last) begin
                  state_d = IDLE;
               end else begin
                  addr_d  = LSB_FIRST ? (addr_q + 2'd1) : (addr_q - 2'd1);
                  cnt_d   = '0;
                  state_d = SETTLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign load_ready = (state_q == IDLE);
   assign in0        = data_q[0];
   assign in1        = data_q[1];
   assign in2        = data_q[2];
   assign in3        = data_q[3];
   assign addr0      = addr_q[0];
   assign addr1      = addr_q[1];
   assign ser_out    = ser_out_q;
   assign ser_valid  = ser_valid_q;
   assign ser_last   = ser_last_q;
   assign mux_err    = mux_err_q;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb/tb_mux_scan_serializer.sv - scoreboard bench for mux_scan_serializer
module tb_mux_scan_serializer;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   // dut_a: SETTLE_CYCLES=1, LSB_FIRST=1
   logic       a_lv, a_lr, a_mux, a_ser, a_sv, a_sr, a_sl, a_err, a_fault;
   logic [3:0] a_ld, a_in;
   logic       a_addr0, a_addr1;
   // dut_b: SETTLE_CYCLES=2, LSB_FIRST=0
   logic       b_lv, b_lr, b_mux, b_ser, b_sv, b_sr, b_sl, b_err;
   logic [3:0] b_ld, b_in;
   logic       b_addr0, b_addr1;

   // expected entries: {ser_out, ser_last, addr[1:0]}
   logic [3:0] sb_q[$];

   always #5 clk = ~clk;

   assign a_mux = a_fault ? 1'b0 : a_in[{a_addr1, a_addr0}];
   assign b_mux = b_in[{b_addr1, b_addr0}];

   mux_scan_serializer #(.SETTLE_CYCLES(1), .LSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .load_valid(a_lv), .load_ready(a_lr), .load_data(a_ld),
      .in0(a_in[0]), .in1(a_in[1]), .in2(a_in[2]), .in3(a_in[3]),
      .addr0(a_addr0), .addr1(a_addr1), .mux_out(a_mux), .ser_out(a_ser),
      .ser_valid(a_sv), .ser_ready(a_sr), .ser_last(a_sl), .mux_err(a_err));

   mux_scan_serializer #(.SETTLE_CYCLES(2), .LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .load_valid(b_lv), .load_ready(b_lr), .load_data(b_ld),
      .in0(b_in[0]), .in1(b_in[1]), .in2(b_in[2]), .in3(b_in[3]),
      .addr0(b_addr0), .addr1(b_addr1), .mux_out(b_mux), .ser_out(b_ser),
      .ser_valid(b_sv), .ser_ready(b_sr), .ser_last(b_sl), .mux_err(b_err));

   task automatic push_exp(input logic [3:0] bits, input bit lsb);
      for (int k = 0; k < 4; k++) begin
         logic [1:0] idx;
         idx = lsb ? 2'(k) : 2'(3 - k);
         sb_q.push_back({bits[idx], (k == 3) ? 1'b1 : 1'b0, idx});
      end
   endtask

   task automatic load_a(input logic [3:0] d, input logic [3:0] exp_bits);
      @(negedge clk);
      a_lv = 1'b1;
      a_ld = d;
      push_exp(exp_bits, 1'b1);
      @(posedge clk);
      #1 a_lv = 1'b0;
      a_ld = 4'hx;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({a_lr, a_sv, a_sl, a_err, a_ser, a_addr1, a_addr0, a_in} !== 11'b100_0000_0000) begin
         errors++;
         $display("FAIL reset_a got %b exp %b", {a_lr, a_sv, a_sl, a_err, a_ser, a_addr1, a_addr0, a_in}, 11'b100_0000_0000);
      end
      checks++;
      if ({b_lr, b_sv, b_sl, b_err, b_ser, b_addr1, b_addr0, b_in} !== 11'b100_0000_0000) begin
         errors++;
         $display("FAIL reset_b got %b exp %b", {b_lr, b_sv, b_sl, b_err, b_ser, b_addr1, b_addr0, b_in}, 11'b100_0000_0000);
      end
   endtask

   task automatic test_lsb_first;
      int first_v = -1;
      int rdy_e   = -1;
      logic [3:0] x;
      a_sr = 1'b1;
      load_a(4'b1010, 4'b1010);
      for (int e = 1; e <= 20 && rdy_e < 0; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (a_sv && first_v < 0) first_v = e;
         if (a_lr) rdy_e = e;
         if (a_sv && a_sr) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL lsb_extra_bit got %b exp none", {a_ser, a_sl, a_addr1, a_addr0});
            end else begin
               x = sb_q.pop_front();
               if ({a_ser, a_sl, a_addr1, a_addr0} !== x || a_in !== 4'b1010) begin
                  errors++;
                  $display("FAIL lsb_bit got %b in %b exp %b in 1010", {a_ser, a_sl, a_addr1, a_addr0}, a_in, x);
               end
            end
         end
      end
      checks++;
      if (first_v != 1) begin errors++; $display("FAIL lsb_first_latency got %0d exp 1", first_v); end
      checks++;
      if (rdy_e != 8) begin errors++; $display("FAIL lsb_ready_back got %0d exp 8", rdy_e); end
      checks++;
      if (sb_q.size() != 0 || a_err !== 1'b0) begin
         errors++;
         $display("FAIL lsb_done left %0d err %b exp 0 0", sb_q.size(), a_err);
      end
      sb_q.delete();
   endtask

   task automatic test_msb_first;
      int first_v = -1;
      int rdy_e   = -1;
      logic [3:0] x;
      b_sr = 1'b1;
      @(negedge clk);
      b_lv = 1'b1;
      b_ld = 4'b0001;
      push_exp(4'b0001, 1'b0);
      @(posedge clk);
      #1 b_lv = 1'b0;
      b_ld = 4'b1111;
      for (int e = 1; e <= 30 && rdy_e < 0; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (b_sv && first_v < 0) first_v = e;
         if (b_lr) rdy_e = e;
         if (b_sv && b_sr) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL msb_extra_bit got %b exp none", {b_ser, b_sl, b_addr1, b_addr0});
            end else begin
               x = sb_q.pop_front();
               if ({b_ser, b_sl, b_addr1, b_addr0} !== x) begin
                  errors++;
                  $display("FAIL msb_bit got %b exp %b", {b_ser, b_sl, b_addr1, b_addr0}, x);
               end
            end
         end
      end
      checks++;
      if (first_v != 2) begin errors++; $display("FAIL msb_first_latency got %0d exp 2", first_v); end
      checks++;
      if (rdy_e != 12) begin errors++; $display("FAIL msb_ready_back got %0d exp 12", rdy_e); end
      checks++;
      if (sb_q.size() != 0 || b_err !== 1'b0 || b_in !== 4'b0001) begin
         errors++;
         $display("FAIL msb_done left %0d err %b in %b exp 0 0 0001", sb_q.size(), b_err, b_in);
      end
      sb_q.delete();
   endtask

   task automatic test_back_pressure;
      int popped = 0;
      int hold   = 0;
      logic [3:0] x;
      a_sr = 1'b1;
      load_a(4'b0110, 4'b0110);
      for (int e = 1; e <= 40 && !(popped == 4 && a_lr); e++) begin
         @(posedge clk);
         #1;
         if (popped == 1 && a_sv && hold < 5) begin
            a_sr = 1'b0;
            hold++;
            checks++;
            if ({a_sv, a_ser, a_addr1, a_addr0} !== 4'b1101) begin
               errors++;
               $display("FAIL bp_hold cycle %0d got %b exp 1101", hold, {a_sv, a_ser, a_addr1, a_addr0});
            end
         end else begin
            a_sr = 1'b1;
         end
         @(negedge clk);
         if (a_sv && a_sr) begin
            checks++;
            popped++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra_bit got %b exp none", {a_ser, a_sl, a_addr1, a_addr0});
            end else begin
               x = sb_q.pop_front();
               if ({a_ser, a_sl, a_addr1, a_addr0} !== x) begin
                  errors++;
                  $display("FAIL bp_bit got %b exp %b", {a_ser, a_sl, a_addr1, a_addr0}, x);
               end
            end
         end
      end
      checks++;
      if (hold != 5 || popped != 4 || !a_lr) begin
         errors++;
         $display("FAIL bp_done hold %0d popped %0d ready %b exp 5 4 1", hold, popped, a_lr);
      end
      sb_q.delete();
      a_sr = 1'b1;
   endtask

   task automatic test_fault;
      int popped  = 0;
      int err_seen = 0;
      logic [3:0] x;
      a_sr    = 1'b1;
      a_fault = 1'b1;
      load_a(4'b1111, 4'b0000);
      for (int e = 1; e <= 20 && !(popped == 4 && a_lr); e++) begin
         @(posedge clk);
         @(negedge clk);
         if (a_sv && a_sr) begin
            checks++;
            popped++;
            if (popped == 1) err_seen = a_err;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL fault_extra_bit got %b exp none", {a_ser, a_sl, a_addr1, a_addr0});
            end else begin
               x = sb_q.pop_front();
               if ({a_ser, a_sl, a_addr1, a_addr0} !== x) begin
                  errors++;
                  $display("FAIL fault_bit got %b exp %b", {a_ser, a_sl, a_addr1, a_addr0}, x);
               end
            end
         end
      end
      checks++;
      if (err_seen != 1) begin errors++; $display("FAIL fault_err_first got %0d exp 1", err_seen); end
      repeat (3) @(negedge clk);
      checks++;
      if (a_err !== 1'b1 || a_lr !== 1'b1) begin
         errors++;
         $display("FAIL fault_err_idle got err %b ready %b exp 1 1", a_err, a_lr);
      end
      a_fault = 1'b0;
      sb_q.delete();
      load_a(4'b0101, 4'b0101);
      @(negedge clk);
      checks++;
      if (a_err !== 1'b0) begin errors++; $display("FAIL fault_err_clear got %b exp 0", a_err); end
      popped = 0;
      for (int e = 1; e <= 20 && !(popped == 4 && a_lr); e++) begin
         @(posedge clk);
         @(negedge clk);
         if (a_sv && a_sr) begin
            checks++;
            popped++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL clean_extra_bit got %b exp none", {a_ser, a_sl, a_addr1, a_addr0});
            end else begin
               x = sb_q.pop_front();
               if ({a_ser, a_sl, a_addr1, a_addr0, a_err} !== {x, 1'b0}) begin
                  errors++;
                  $display("FAIL clean_bit got %b err %b exp %b err 0", {a_ser, a_sl, a_addr1, a_addr0}, a_err, x);
               end
            end
         end
      end
      checks++;
      if (popped != 4) begin errors++; $display("FAIL clean_count got %0d exp 4", popped); end
      sb_q.delete();
   endtask

   task automatic test_reset_mid_word;
      int popped = 0;
      int reached = 0;
      int late_v = 0;
      a_sr = 1'b1;
      load_a(4'b1011, 4'b1011);
      for (int e = 1; e <= 20 && reached == 0; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (a_sv && popped == 2) reached = 1;
         else if (a_sv && a_sr) popped++;
      end
      checks++;
      if (reached != 1) begin errors++; $display("FAIL mid_reach got %0d exp 1", reached); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({a_sv, a_sl, a_addr1, a_addr0, a_in, a_ser} !== 9'b0) begin
         errors++;
         $display("FAIL mid_async got %b exp 000000000", {a_sv, a_sl, a_addr1, a_addr0, a_in, a_ser});
      end
      @(negedge clk);
      rst_n = 1'b1;
      sb_q.delete();
      #1;
      checks++;
      if (a_lr !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", a_lr); end
      repeat (6) begin
         @(negedge clk);
         if (a_sv || a_sl) late_v++;
      end
      checks++;
      if (late_v != 0) begin errors++; $display("FAIL mid_no_output got %0d exp 0", late_v); end
   endtask

   initial begin
      a_lv = 1'b0; a_ld = 4'h0; a_sr = 1'b1; a_fault = 1'b0;
      b_lv = 1'b0; b_ld = 4'h0; b_sr = 1'b1;
      test_reset;
      test_lsb_first;
      test_msb_first;
      test_back_pressure;
      test_fault;
      test_reset_mid_word;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
